regfile_read_arbiter: RTL



---
 rtl/regfile_read_arbiter_pkg.sv | 20 ++
 rtl/regfile_read_arbiter_if.sv | 37 +++
 rtl/regfile_read_arbiter_picker.sv | 44 ++++
 rtl/regfile_read_arbiter.sv | 87 ++++++++
 4 files changed

// File: rtl/regfile_read_arbiter_pkg.sv
// Purpose: shared constants and types for the register-file read-port arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package regfile_arb_pkg;

  localparam int DATA_WIDTH = 64;
  localparam int ADDR_WIDTH = 5;

  // Index 31 is the zero register; reads of it return 0 regardless of the array.
  localparam logic [ADDR_WIDTH-1:0] XZR_ADDR = 5'd31;

  typedef logic [DATA_WIDTH-1:0] rf_data_t;
  typedef logic [ADDR_WIDTH-1:0] rf_addr_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } rsp_state_t;

endpackage

// File: rtl/regfile_read_arbiter_if.sv
// Purpose: request/response bundle between read clients, the arbiter and the read port.
// Latency: n/a (wires only).
// Backpressure: req_ready gates requests, rsp_ready stalls the response register.
// Signals:
//   req_valid/req_addr/req_ready : per-requester valid/ready read request
//   rf_read_reg/rf_read_data     : read-port select and its combinational data
//   rsp_valid/rsp_id/rsp_data    : registered response, accepted by rsp_ready
interface regfile_read_arbiter_if #(
  parameter int NUM_REQ = 4
);
  import regfile_arb_pkg::*;

  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  rf_addr_t [NUM_REQ-1:0]        req_addr;
  logic [NUM_REQ-1:0]            req_ready;
  rf_addr_t                      rf_read_reg;
  rf_data_t                      rf_read_data;
  logic                          rsp_valid;
  logic [ID_W-1:0]               rsp_id;
  rf_data_t                      rsp_data;
  logic                          rsp_ready;

  // Arbiter side.
  modport slave (
    input  req_valid, req_addr, rf_read_data, rsp_ready,
    output req_ready, rf_read_reg, rsp_valid, rsp_id, rsp_data
  );

  // Client / register-file side.
  modport master (
    output req_valid, req_addr, rf_read_data, rsp_ready,
    input  req_ready, rf_read_reg, rsp_valid, rsp_id, rsp_data
  );

endinterface

// File: rtl/regfile_read_arbiter_picker.sv
// Purpose: round-robin first-set picker, searching upward from rr_ptr modulo NUM_REQ.
// Latency: purely combinational.
// Backpressure: enable_i low forces no grant.
// Ports: req_i (request vector), rr_ptr_i (search start), enable_i,
//        grant_o (one-hot), grant_idx_o (encoded), any_grant_o.
module rr_priority_picker #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    rr_ptr_i,
  input  logic               enable_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [ID_W-1:0]    grant_idx_o,
  output logic               any_grant_o
);

  // rr_ptr is always < NUM_REQ, so a single conditional subtract wraps it.
  function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return ID_W'(s);
  endfunction

  // Walk the search order backwards so the earliest hit overwrites later ones.
  always_comb begin
    logic [ID_W-1:0] idx;
    grant_o     = '0;
    grant_idx_o = '0;
    any_grant_o = 1'b0;
    idx         = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = wrap_idx(rr_ptr_i, k);
      if (enable_i && req_i[idx]) begin
        grant_o      = '0;
        grant_o[idx] = 1'b1;
        grant_idx_o  = idx;
        any_grant_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_read_arbiter.sv
// Purpose: round-robin share of one register-file read port among NUM_REQ clients.
// Latency: request accepted at edge N shows its response in cycle N+1; one per cycle.
// Backpressure: rsp_ready low with a held response blocks all req_ready.
// Ports: clk, reset (synchronous, active-high), rd_if (slave side of the bundle).
module regfile_read_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  regfile_read_arbiter_if.slave  rd_if
);

  localparam int ID_W = $clog2(NUM_REQ);

  rsp_state_t       state_q, state_d;
  rf_data_t         rsp_data_q, rsp_data_d;
  logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;

  logic               can_issue;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic               any_grant;
  rf_addr_t           sel_addr;

  // A new result can load if the register is empty or drains on this edge.
  // Reset blocks issue so req_ready and rf_read_reg are 0 in the reset cycle.
  assign can_issue = (state_q == EMPTY) || rd_if.rsp_ready;

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_picker (
    .req_i       (rd_if.req_valid),
    .rr_ptr_i    (rr_ptr_q),
    .enable_i    (can_issue && !reset),
    .grant_o     (grant),
    .grant_idx_o (grant_idx),
    .any_grant_o (any_grant)
  );

  assign sel_addr = rd_if.req_addr[grant_idx];

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= EMPTY;
      rsp_data_q <= '0;
      rsp_id_q   <= '0;
      rr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      rsp_data_q <= rsp_data_d;
      rsp_id_q   <= rsp_id_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  // Next state. A grant always loads (covers same-edge retire+load when FULL).
  always_comb begin
    state_d    = state_q;
    rsp_data_d = rsp_data_q;
    rsp_id_d   = rsp_id_q;
    rr_ptr_d   = rr_ptr_q;
    if (any_grant) begin
      state_d = FULL;
      // XZR test uses the address, keeping the compare off the read-data path.
      rsp_data_d = (sel_addr == XZR_ADDR) ? '0 : rd_if.rf_read_data;
      rsp_id_d   = grant_idx;
      rr_ptr_d   = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
    end else if ((state_q == FULL) && rd_if.rsp_ready) begin
      state_d = EMPTY;
    end
  end

  // Outputs.
  always_comb begin
    rd_if.req_ready   = grant;
    rd_if.rf_read_reg = any_grant ? sel_addr : '0;
    rd_if.rsp_valid   = (state_q == FULL);
    rd_if.rsp_id      = rsp_id_q;
    rd_if.rsp_data    = rsp_data_q;
  end

endmodule
